// File: rtl/alu_input_sequencer.sv
// Captures operand A, operand B and an op code for an ALU from a push-button style load input.
// Define ALU_SEQ_SYNC_EN to insert a two-flop synchronizer on load (for an asynchronous button).
module alu_input_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic [3:0]   op_in,
  input  logic         load,
  input  logic         clear,
  input  logic         out_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   sel,
  output logic         out_valid,
  output logic         err,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_EXEC = 2'b11
  } state_t;

  state_t cur;
  logic   load_s;
  logic   load_q;
  logic   load_evt;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1000, 4'b1001,
      4'b1100, 4'b1101: op_legal = 1'b1;
      default:          op_legal = 1'b0;
    endcase
  endfunction

  // Stage p0/p1: optional metastability guard on the button input
`ifdef ALU_SEQ_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= load;
      sync_p1 <= sync_p0;
    end
  end

  assign load_s = sync_p1;
`else
  assign load_s = load;
`endif

  // Edge detect: a held button yields a single event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= 1'b0;
    end else begin
      load_q <= load_s;
    end
  end

  assign load_evt = load_s & ~load_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_A;
      a   <= '0;
      b   <= '0;
      sel <= '0;
      err <= 1'b0;
    end else if (clear) begin
      cur <= S_A;
      a   <= '0;
      b   <= '0;
      sel <= '0;
      err <= 1'b0;
    end else begin
      case (cur)
        S_A: begin
          if (load_evt) begin
            a   <= data_in;
            cur <= S_B;
          end
        end
        S_B: begin
          if (load_evt) begin
            b   <= data_in;
            cur <= S_OP;
          end
        end
        S_OP: begin
          if (load_evt) begin
            if (op_legal(op_in)) begin
              sel <= op_in;
              err <= 1'b0;
              cur <= S_EXEC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          // Load events here are dropped; operands stay frozen until accepted
          if (out_ready) begin
            cur <= S_A;
          end
        end
        default: cur <= S_A;
      endcase
    end
  end

  assign out_valid = (cur == S_EXEC);
  assign state     = cur;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer; expected snapshots are queued from a reference model
// and popped when the DUT has had time to produce them. Honors ALU_SEQ_SYNC_EN for load latency.
module tb_alu_input_sequencer;

`ifdef ALU_SEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic [3:0] op_in;
  logic       load;
  logic       clear;
  logic       out_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel;
  logic       out_valid;
  logic       err;
  logic [1:0] state;

  alu_input_sequencer #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .op_in     (op_in),
    .load      (load),
    .clear     (clear),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic       err;
    logic [1:0] state;
    logic       vld;
  } snap_t;

  snap_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_a, m_b, m_sel;
  logic       m_err;
  logic [1:0] m_state;

  function automatic logic legal(input logic [3:0] op);
    logic [3:0] tbl [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD};
    legal = 1'b0;
    for (int i = 0; i < 10; i++) if (tbl[i] == op) legal = 1'b1;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_zero();
    m_a = '0; m_b = '0; m_sel = '0; m_err = 1'b0; m_state = 2'b00;
  endtask

  task automatic push_exp();
    snap_t s;
    s.a = m_a; s.b = m_b; s.sel = m_sel; s.err = m_err;
    s.state = m_state; s.vld = (m_state == 2'b11);
    sb.push_back(s);
  endtask

  task automatic check_all(input string tag);
    snap_t s;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      s = sb.pop_front();
      cmp({tag, "_a"},     a,         s.a);
      cmp({tag, "_b"},     b,         s.b);
      cmp({tag, "_sel"},   sel,       s.sel);
      cmp({tag, "_err"},   err,       s.err);
      cmp({tag, "_state"}, state,     s.state);
      cmp({tag, "_vld"},   out_valid, s.vld);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_event(input logic [3:0] d, input logic [3:0] op);
    case (m_state)
      2'b00: begin m_a = d; m_state = 2'b01; end
      2'b01: begin m_b = d; m_state = 2'b10; end
      2'b10: begin
        if (legal(op)) begin m_sel = op; m_err = 1'b0; m_state = 2'b11; end
        else m_err = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Raise load for 'hold' cycles (>= LAT), checking capture lands exactly LAT edges after the rise
  task automatic load_step(input string tag, input logic [3:0] d, input logic [3:0] op,
                           input int hold);
    data_in = d;
    op_in   = op;
    load    = 1'b1;
    repeat (LAT - 1) tick();
    cmp({tag, "_early"}, state, m_state);
    tick();
    model_event(d, op);
    push_exp();
    check_all(tag);
    if (hold > LAT) begin
      repeat (hold - LAT) tick();
      cmp({tag, "_held"}, state, m_state);
    end
    load = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  initial begin
    rst = 1'b1; data_in = '0; op_in = '0; load = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_zero();
    #1;
    push_exp();
    check_all("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full capture sequence with ADD
    load_step("ld_a",   4'h1, 4'h0, LAT);
    load_step("ld_b",   4'h1, 4'h0, LAT);
    load_step("ld_add", 4'h0, 4'h8, LAT);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_state = 2'b00;
    push_exp();
    check_all("xfer1");

    // Illegal code then legal XOR
    load_step("ld_a2",   4'hA, 4'h0, LAT);
    load_step("ld_b2",   4'h6, 4'h0, LAT);
    load_step("ld_ill",  4'h0, 4'h6, LAT);
    load_step("ld_ill2", 4'h0, 4'hF, LAT);
    load_step("ld_xor",  4'h0, 4'h3, LAT);

    // Back-pressure: hold in EXEC, loads discarded
    repeat (10) tick();
    load_step("exec_ld1", 4'hF, 4'h1, LAT);
    load_step("exec_ld2", 4'h7, 4'h2, LAT);
    push_exp();
    check_all("exec_hold");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_state = 2'b00;
    push_exp();
    check_all("xfer2");

    // Load held for 20 cycles captures only once
    load_step("hold20", 4'h5, 4'h0, 20);

    // Clear wins over a coincident load event in S_B
    data_in = 4'h9;
    load    = 1'b1;
    repeat (LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    push_exp();
    check_all("clear");
    load = 1'b0;
    repeat (LAT + 1) tick();

    // Async reset mid-sequence from S_OP
    load_step("ld_a3", 4'hC, 4'h0, LAT);
    load_step("ld_b3", 4'h3, 4'h0, LAT);
    load_step("ld_ill3", 4'h0, 4'hE, LAT);
    #2;
    rst = 1'b1;
    #1;
    model_zero();
    push_exp();
    check_all("async_rst");
    #1;
    rst = 1'b0;
    tick();
    load_step("post_rst", 4'h3, 4'h0, LAT);

    cmp("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
